// File: rtl/fifo_sync_prog.sv
// Single-clock programmable FIFO with almost-empty/almost-full offsets,
// optional first-word-fall-through output, fill level and sticky error flags.
module fifo_sync_prog #(
    parameter int unsigned WIDTH       = 9,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned FWFT        = 0,
    parameter int unsigned PAE_DEFAULT = 7,
    parameter int unsigned PAF_DEFAULT = 7
) (
    input  logic                  CLK,
    input  logic                  RS,
    input  logic [WIDTH-1:0]      D,
    input  logic                  WEN,
    input  logic                  REN,
    input  logic                  LD,
    input  logic                  OE,
    output logic [WIDTH-1:0]      Q,
    output logic                  EF,
    output logic                  FF,
    output logic                  PAE,
    output logic                  PAF,
    output logic [ADDR_WIDTH:0]   WCOUNT,
    output logic                  OVF,
    output logic                  UNF
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [PW-1:0]         wptr_nx, rptr_nx, count_nx, paf_limit;
    logic [ADDR_WIDTH-1:0] empty_off, full_off;
    logic [ADDR_WIDTH-1:0] empty_off_nx, full_off_nx;
    logic                  sel;
    logic [WIDTH-1:0]      q_reg;
    logic                  q_from_reg;
    logic [WIDTH-1:0]      q_src;
    logic                  wr_ok, rd_ok, off_wr, off_rd;

    // Decode this cycle's operation; full/empty are judged on the current flags.
    always_comb begin
        wr_ok        = !WEN && LD && !FF;
        rd_ok        = !REN && LD && !EF;
        off_wr       = !WEN && !LD;
        off_rd       = !REN && WEN && !LD;
        wptr_nx      = wptr + PW'(wr_ok);
        rptr_nx      = rptr + PW'(rd_ok);
        empty_off_nx = (off_wr && !sel) ? D[ADDR_WIDTH-1:0] : empty_off;
        full_off_nx  = (off_wr &&  sel) ? D[ADDR_WIDTH-1:0] : full_off;
        count_nx     = wptr_nx - rptr_nx;
        paf_limit    = PW'(DEPTH) - PW'(full_off_nx);
    end

    always_ff @(posedge CLK) begin
        if (RS && wr_ok) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= D;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RS) begin
            wptr       <= '0;
            rptr       <= '0;
            q_reg      <= '0;
            q_from_reg <= 1'b0;
            EF         <= 1'b1;
            FF         <= 1'b0;
            PAE        <= 1'b1;
            PAF        <= 1'b0;
            OVF        <= 1'b0;
            UNF        <= 1'b0;
            empty_off  <= ADDR_WIDTH'(PAE_DEFAULT);
            full_off   <= ADDR_WIDTH'(PAF_DEFAULT);
            sel        <= 1'b0;
        end else begin
            wptr       <= wptr_nx;
            rptr       <= rptr_nx;
            empty_off  <= empty_off_nx;
            full_off   <= full_off_nx;
            EF         <= (count_nx == '0);
            FF         <= (count_nx == PW'(DEPTH));
            PAE        <= (count_nx <= PW'(empty_off_nx));
            PAF        <= (count_nx >= paf_limit);
            q_from_reg <= off_rd;
            if (!WEN && LD && FF) OVF <= 1'b1;
            if (!REN && LD && EF) UNF <= 1'b1;
            if (off_wr || off_rd) sel <= ~sel;
            if (off_rd) begin
                q_reg <= WIDTH'(sel ? full_off : empty_off);
            end else if (rd_ok && FWFT == 0) begin
                q_reg <= mem[rptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    // FWFT shows the head word directly, except the cycle after an offset readback.
    always_comb begin
        q_src = q_reg;
        if (FWFT != 0 && !q_from_reg) begin
            q_src = EF ? '0 : mem[rptr[ADDR_WIDTH-1:0]];
        end
    end

    assign Q      = OE ? q_src : '0;
    assign WCOUNT = wptr - rptr;

endmodule

// File: doc/fifo_sync_prog.md
Name: fifo_sync_prog

Overview:
- Parametrised single-clock FIFO for the IDT72V2xx-style macro family; next generation of the dual-clock 256x9 block.
- Adds configurable width and depth, an optional first-word-fall-through (FWFT) mode and offset-register readback.
- Adds a fill-level output and sticky overflow/underflow error flags.
- Used as the digital core in mixed-signal buffering testcases, with flags feeding analog comparators and level monitors.

Parameters:
- WIDTH, 9, data word width in bits.
- ADDR_WIDTH, 8, log2 of depth. DEPTH = 2**ADDR_WIDTH.
- FWFT, 0, 0 = standard mode, 1 = first-word-fall-through mode.
- PAE_DEFAULT, 7, reset value of the empty offset.
- PAF_DEFAULT, 7, reset value of the full offset.

Ports:
- CLK  in  1  single clock; all state changes on its rising edge.
- RS  in  1  reset, synchronous, active-low.
- D  in  WIDTH  write data, or offset load value when LD=0.
- WEN  in  1  write enable, active low.
- REN  in  1  read enable, active low.
- LD  in  1  offset-register access select, active low.
- OE  in  1  output enable, active high. Q forced to 0 when OE=0.
- Q  out  WIDTH  read data or offset readback.
- EF  out  1  empty flag, 1 = empty.
- FF  out  1  full flag, 1 = full.
- PAE  out  1  programmable almost-empty flag.
- PAF  out  1  programmable almost-full flag.
- WCOUNT  out  ADDR_WIDTH+1  stored word count, 0..DEPTH.
- OVF  out  1  sticky: write attempted while full.
- UNF  out  1  sticky: read attempted while empty.

Behaviour:
- Reset: RS=0 sampled at a CLK edge resets the block. Pointers, count and Q_reg go to 0. EF=1, FF=0, PAE=1, PAF=0, OVF=0, UNF=0. Offsets return to their defaults; the offset-select bit returns to 0. Reset overrides any WEN/REN/LD activity in the same cycle, including reset mid-stream; memory contents are not cleared.
- Storage: DEPTH x WIDTH array. Pointers are ADDR_WIDTH+1 bits and wrap modulo 2**(ADDR_WIDTH+1). Memory is indexed by the low ADDR_WIDTH bits. WCOUNT = wptr - rptr.
- Write accepted when WEN=0, LD=1, FF=0: mem[wptr] <= D, wptr+1.
- Write with FF=1: write dropped, OVF <= 1.
- Read accepted when REN=0, LD=1, EF=0: rptr+1.
- Read with EF=1: no read, Q unchanged, UNF <= 1.
- Full and empty are judged on the flag values before the edge. There is no write-through when full and no read-through when empty.
- Simultaneous accepted read and write: both pointers advance and WCOUNT is unchanged.
- FWFT=0 (standard): on an accepted read, Q_reg <= mem[rptr], visible one cycle after the REN edge. Q_reg holds otherwise.
- FWFT=1: Q shows mem[rptr] combinationally whenever EF=0, so the head word is visible with no read. REN=0 pops it, and the next word appears after the edge. Q = 0 while EF=1.
- Q = OE ? (selected source) : 0.
- Flags are registered from the post-edge count (n):
  - EF = (n == 0)
  - FF = (n == DEPTH)
  - PAE = (n <= empty_off)
  - PAF = (n >= DEPTH - full_off)
  - If full_off >= DEPTH, PAF = 1.
  - Flags therefore change on the same edge as the accepted operation.
- Offset access, LD=0:
  - FIFO data reads and writes are suppressed, with no OVF/UNF updates.
  - Offset registers are ADDR_WIDTH bits wide and loaded from D[ADDR_WIDTH-1:0].
  - The sel bit chooses: 0 = empty_off, 1 = full_off.
  - WEN=0: write selected offset, sel toggles.
  - REN=0: Q_reg <= zero-extended selected offset (visible next cycle in both modes; in FWFT=1 the Q mux selects Q_reg for that cycle), sel toggles.
  - WEN=0 and REN=0 together: write wins, sel toggles once.
  - Flags re-evaluate with the new offsets on the next edge.
- OVF and UNF clear only on reset.

Test Plan:
- Reset then idle, ADDR_WIDTH=4, WIDTH=9: EF=1, FF=0, PAE=1, PAF=0, WCOUNT=0, Q=0.
- Fill 16 words 0x100..0x10F, then one extra write → FF=1 on the edge of the 16th write. PAF=1 from count 9. Extra write leaves WCOUNT=16 and sets OVF=1.
- FWFT=0, read-back of the previous fill → Q=0x100..0x10F, each one cycle after its REN edge. EF=1 after the 16th read. A 17th read sets UNF=1 and Q stays 0x10F.
- FWFT=1, single write 0x05A → Q=0x05A one cycle later with no REN. REN pops it → EF=1, Q=0.
- LD=0 load empty_off=2 and full_off=3, then read both back → Q=2 then Q=3. With LD=1, 3 writes → PAE=0 at count 3; at count 13 → PAF=1.
- Pointer wrap and simultaneous ops: 40 cycles of write+read at count 5 → WCOUNT stays 5, data order preserved across the wrap. RS=0 mid-stream → all flags reset the same edge and WCOUNT=0.
